// File: rtl/coherency_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// coherency_ctrl_pkg
// Shared types and constants for the coherency retry/backoff logic.
//   backoff_t      : 16-bit backoff count handed to backoff_unit
//   sched_state_t  : backoff_sched FSM states
//   LFSR_SEED/TAPS : 16-bit Fibonacci LFSR used for optional jitter
//                    (taps 16,14,13,11 -> bit positions 15,13,12,10)
// ---------------------------------------------------------------------------
package coherency_ctrl_pkg;

  typedef logic [15:0] backoff_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } sched_state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Shift left, new bit is the XOR of the tapped bits.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick: the first asserted request found
// when scanning upward from ptr (wrapping) wins.
//   req   in  NUM_REQ          request vector
//   ptr   in  $clog2(NUM_REQ)  index with highest priority this cycle
//   grant out NUM_REQ          one-hot winner (zero when no request)
//   idx   out $clog2(NUM_REQ)  winner index (zero when no request)
//   any   out 1                at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] idx,
  output logic                       any
);

  localparam int IW = $clog2(NUM_REQ);

  int cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(ptr) + k) % NUM_REQ;
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/backoff_sched.sv
// ---------------------------------------------------------------------------
// backoff_sched
// Shares one backoff_unit timer among NUM_REQ retry requesters. Requests are
// granted round-robin; the winner's backoff is BASE_BACKOFF << attempt,
// clamped to MAX_VALUE, where attempt counts its consecutive failures.
//
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   req           level request per requester (held until done or cancel)
//   cancel        pulse, requester aborts its backoff
//   success       pulse, requester succeeded, clears its attempt count
//   done          one-hot 1-cycle pulse, backoff finished for the owner
//   busy          timer owned by some requester
//   owner         index of current owner (valid while busy)
//   bo_valid      launch strobe to backoff_unit (single cycle)
//   bo_interrupt  abort strobe to backoff_unit (single cycle)
//   bo_value      backoff count to backoff_unit, latched at grant
//   bo_ack        expiry from backoff_unit
//   dbg_state     current FSM state (sched_state_t encoding)
//
// Handshake with backoff_unit: bo_valid is a one-cycle strobe raised only in
// S_ISSUE; bo_value is stable from the grant until the next grant; bo_ack is
// consumed only in S_WAIT and beats a coincident cancel.
//
// Optional build macro BACKOFF_SCHED_JITTER_EN adds LFSR jitter of up to 50%
// of the base value at grant time.
// ---------------------------------------------------------------------------
module backoff_sched
  import coherency_ctrl_pkg::*;
#(
  parameter int          NUM_REQ      = 4,
  parameter int unsigned BASE_BACKOFF = 16,
  parameter int          MAX_SHIFT    = 6,
  parameter int unsigned MAX_VALUE    = 32'h0000_FFFF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         cancel,
  input  logic [NUM_REQ-1:0]         success,
  output logic [NUM_REQ-1:0]         done,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                       bo_valid,
  output logic                       bo_interrupt,
  output logic [15:0]                bo_value,
  input  logic                       bo_ack,
  output logic [1:0]                 dbg_state
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int AW = (MAX_SHIFT < 1) ? 1 : $clog2(MAX_SHIFT + 1);

  sched_state_t   state_q, state_d;
  logic [IW-1:0]  owner_q, owner_d;
  logic [IW-1:0]  ptr_q, ptr_d;
  backoff_t       value_q, value_d;
  logic [AW-1:0]  attempt_q [NUM_REQ];
  logic [AW-1:0]  attempt_d [NUM_REQ];

  logic [NUM_REQ-1:0] arb_grant;
  logic [IW-1:0]      arb_idx;
  logic               arb_any;

  logic [AW-1:0] win_attempt;
  logic [31:0]   shifted;
  logic [31:0]   sum;
  backoff_t      grant_value;
  logic          cancel_own;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req   (req),
    .ptr   (ptr_q),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

`ifdef BACKOFF_SCHED_JITTER_EN
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_next(lfsr_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= lfsr_d;
  end
`endif

  // Backoff for the current arbitration winner. The one-hot grant selects
  // the winner's attempt count so no index decode is needed here.
  always_comb begin
    win_attempt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) win_attempt = win_attempt | attempt_q[i];
    end
    shifted = BASE_BACKOFF << win_attempt;
`ifdef BACKOFF_SCHED_JITTER_EN
    // Jitter is below half the base value: random bits under the base's
    // power-of-two mask, halved.
    sum = shifted + 32'((lfsr_q & backoff_t'(shifted - 32'd1)) >> 1);
`else
    sum = shifted;
`endif
    grant_value = (sum > MAX_VALUE) ? backoff_t'(MAX_VALUE) : sum[15:0];
  end

  assign cancel_own = cancel[owner_q];

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    ptr_d        = ptr_q;
    value_d      = value_q;
    attempt_d    = attempt_q;
    busy         = 1'b0;
    bo_valid     = 1'b0;
    bo_interrupt = 1'b0;
    done         = '0;

    case (state_q)
      S_IDLE: begin
        if (arb_any) begin
          owner_d = arb_idx;
          value_d = grant_value;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        busy = 1'b1;
        // A cancel in the launch cycle means the timer never starts.
        if (cancel_own) begin
          state_d = S_IDLE;
        end else begin
          bo_valid = 1'b1;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        busy = 1'b1;
        if (bo_ack) begin
          state_d = S_DONE;
        end else if (cancel_own) begin
          bo_interrupt = 1'b1;
          state_d      = S_IDLE;
        end
      end
      S_DONE: begin
        busy           = 1'b1;
        done[owner_q]  = 1'b1;
        if (attempt_q[owner_q] < AW'(MAX_SHIFT)) begin
          attempt_d[owner_q] = attempt_q[owner_q] + AW'(1);
        end
        ptr_d   = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + IW'(1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Applied last so a success beats the S_DONE increment.
    for (int i = 0; i < NUM_REQ; i++) begin
      if (success[i]) attempt_d[i] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      value_q <= '0;
      for (int i = 0; i < NUM_REQ; i++) attempt_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      value_q   <= value_d;
      attempt_q <= attempt_d;
    end
  end

  assign owner     = owner_q;
  assign bo_value  = value_q;
  assign dbg_state = state_q;

endmodule
